instruction_fetch_unit: RTL and testbench

Fetch stage of the 16-bit pipelined CPU: owns the program counter and issues one-at-a-time read requests to instruction memory. It delivers each instruction with its PC to the IF/ID stage register through `out_instruction`, `out_PC` and `out_valid`. It honours back-pressure from the stall logic and accepts branch/jump redirects from later stages, discarding any instruction fetched down the wrong path.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/fetch_skid_buffer.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM states and PC sizing.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    // Instruction memory is word-addressed, so sequential fetch steps by one.
    localparam int unsigned PC_INCR       = 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port: one request in flight, response returned on rvalid.
interface instruction_fetch_unit_if #(
    parameter int unsigned WIDTH = cpu_pkg::DEFAULT_WIDTH
) ();

    logic             req;
    logic [WIDTH-1:0] addr;
    logic             ready;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Single-entry {instruction, PC} holding register used while the output slot is stalled.
module fetch_skid_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic             flush,
    input  logic [WIDTH-1:0] load_instruction,
    input  logic [WIDTH-1:0] load_pc,
    output logic             full,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] pc
);

    // Flush wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full        <= 1'b0;
            instruction <= '0;
            pc          <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full        <= 1'b1;
            instruction <= load_instruction;
            pc          <= load_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues one-at-a-time imem reads and feeds the IF/ID slot,
// absorbing stalls with a skid buffer and discarding wrong-path responses after redirects.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    instruction_fetch_unit_if.master imem,
    output logic [WIDTH-1:0]         out_instruction,
    output logic [WIDTH-1:0]         out_PC,
    output logic                     out_valid
);

    fetch_state_t     state, state_d;
    logic [WIDTH-1:0] pc, pc_d, pc_next;
    logic             drop, drop_d;
    logic             slot_valid_d;
    logic [WIDTH-1:0] slot_instruction_d, slot_pc_d;
    logic             accept, slot_free;
    logic             buf_load, buf_unload, buf_flush, buf_full;
    logic [WIDTH-1:0] buf_instruction, buf_pc;

    assign pc_next   = pc + WIDTH'(PC_INCR);
    assign accept    = (state == FETCH) && imem.ready;
    assign slot_free = !out_valid || !stall;

    // Request is a decode of the state register, gated so nothing is issued during reset.
    assign imem.req  = reset && (state == FETCH);
    assign imem.addr = pc;

    fetch_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk              (clk),
        .reset            (reset),
        .load             (buf_load),
        .unload           (buf_unload),
        .flush            (buf_flush),
        .load_instruction (imem.rdata),
        .load_pc          (pc),
        .full             (buf_full),
        .instruction      (buf_instruction),
        .pc               (buf_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            drop            <= 1'b0;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_PC          <= '0;
        end else begin
            state           <= state_d;
            pc              <= pc_d;
            drop            <= drop_d;
            out_valid       <= slot_valid_d;
            out_instruction <= slot_instruction_d;
            out_PC          <= slot_pc_d;
        end
    end

    always_comb begin
        state_d            = state;
        pc_d               = pc;
        drop_d             = drop;
        slot_valid_d       = out_valid;
        slot_instruction_d = out_instruction;
        slot_pc_d          = out_PC;
        buf_load           = 1'b0;
        buf_unload         = 1'b0;
        buf_flush          = 1'b0;

        // An unstalled slot is consumed by IF/ID; data fields keep their last value.
        if (!stall) begin
            slot_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d         = redirect_pc;
            slot_valid_d = 1'b0;
            buf_flush    = 1'b1;
            drop_d       = 1'b0;
            state_d      = FETCH;
            // A response still owed by memory belongs to the old path and must be eaten.
            if (accept || ((state == WAIT) && !imem.rvalid)) begin
                drop_d  = 1'b1;
                state_d = WAIT;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        state_d = FETCH;
                        if (drop) begin
                            drop_d = 1'b0;
                        end else if (slot_free) begin
                            slot_valid_d       = 1'b1;
                            slot_instruction_d = imem.rdata;
                            slot_pc_d          = pc;
                            pc_d               = pc_next;
                        end else begin
                            buf_load = 1'b1;
                            pc_d     = pc_next;
                            state_d  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        buf_unload = 1'b1;
                        state_d    = FETCH;
                        if (buf_full) begin
                            slot_valid_d       = 1'b1;
                            slot_instruction_d = buf_instruction;
                            slot_pc_d          = buf_pc;
                        end
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural imem with adjustable latency/ready and a
// queue of expected {instruction, PC} deliveries popped whenever IF/ID loads the slot.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] out_instruction;
    logic [15:0] out_PC;
    logic        out_valid;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] sb[$];

    logic        ready_val  = 1'b1;
    logic        rand_ready = 1'b0;
    int          mem_lat    = 0;
    logic        mem_busy;
    int          mem_cnt;
    logic [15:0] mem_a;

    instruction_fetch_unit_if #(.WIDTH(16)) imem ();

    instruction_fetch_unit #(
        .WIDTH    (16),
        .RESET_PC (16'h0010)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem),
        .out_instruction (out_instruction),
        .out_PC          (out_PC),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] expv(input logic [15:0] a);
        return {mem_word(a), a};
    endfunction

    // Ready changes on the falling edge so it is stable at the sampling edge.
    always @(negedge clk) imem.ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;

    // Memory: rvalid mem_lat cycles after the cycle following acceptance; reset shared with DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_busy    <= 1'b0;
            mem_cnt     <= 0;
            mem_a       <= '0;
            imem.rvalid <= 1'b0;
            imem.rdata  <= '0;
        end else begin
            imem.rvalid <= 1'b0;
            if (mem_busy) begin
                if (mem_cnt == 0) begin
                    imem.rvalid <= 1'b1;
                    imem.rdata  <= mem_word(mem_a);
                    mem_busy    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end else if (imem.req && imem.ready) begin
                if (mem_lat == 0) begin
                    imem.rvalid <= 1'b1;
                    imem.rdata  <= mem_word(imem.addr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_a    <= imem.addr;
                    mem_cnt  <= mem_lat - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released at posedge+1, i.e. at the start of the first post-reset cycle.
    task automatic do_reset();
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        reset       = 1'b1;
        #1 reset = 1'b0;
        tick();
        tick();
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if (out_instruction !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", out_instruction);
        else pass_cnt++;
        check_cnt++;
        if (out_PC !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", out_PC);
        else pass_cnt++;
        check_cnt++;
        if (imem.req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem.req);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] e;
        int          last_del;
        logic        rv_prev;
        sb.delete();
        ready_val = 1'b1;
        mem_lat   = 0;
        reset     = 1'b1;
        #1;
        check_cnt++;
        if ({imem.req, imem.addr} !== {1'b1, 16'h0010})
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0010", imem.req, imem.addr);
        else pass_cnt++;
        for (int a = 'h10; a <= 'h15; a++) sb.push_back(expv(16'(a)));
        last_del = -1;
        rv_prev  = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
            if (rv_prev) begin
                check_cnt++;
                if (out_valid !== 1'b1) $display("FAIL rvalid_to_valid: got %b want 1", out_valid);
                else pass_cnt++;
            end
            rv_prev = imem.rvalid;
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL stream_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
                if (last_del >= 0) begin
                    check_cnt++;
                    if (i - last_del !== 2) $display("FAIL throughput: got spacing %0d want 2", i - last_del);
                    else pass_cnt++;
                end
                last_del = i;
            end
        end
        stall = 1'b1;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL stream_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] e;
        int          scnt;
        bit          started;
        int          last_del;
        sb.delete();
        ready_val = 1'b0;
        mem_lat   = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect  = 1'b0;
        ready_val = 1'b1;
        check_cnt++;
        if ({imem.req, imem.addr} !== {1'b1, 16'h0020})
            $display("FAIL redirect_first_req: got req=%b addr=%h want req=1 addr=0020", imem.req, imem.addr);
        else pass_cnt++;
        sb.push_back(expv(16'h0020));
        sb.push_back(expv(16'h0021));
        sb.push_back(expv(16'h0022));
        started  = 1'b0;
        scnt     = 0;
        last_del = -100;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
            if (!started && out_valid) started = 1'b1;
            if (started && scnt < 5) begin
                stall = 1'b1;
                check_cnt++;
                if ({out_valid, out_PC} !== {1'b1, 16'h0020})
                    $display("FAIL stall_hold: got valid=%b pc=%h want valid=1 pc=0020", out_valid, out_PC);
                else pass_cnt++;
                if (scnt >= 1) begin
                    check_cnt++;
                    if (imem.req !== 1'b0) $display("FAIL stall_no_req: got %b want 0", imem.req);
                    else pass_cnt++;
                end
                scnt++;
            end else begin
                stall = 1'b0;
            end
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL stall_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
                if (e[15:0] == 16'h0021) begin
                    check_cnt++;
                    if (i - last_del !== 1) $display("FAIL skid_next_cycle: got spacing %0d want 1", i - last_del);
                    else pass_cnt++;
                    check_cnt++;
                    if ({imem.req, imem.addr} !== {1'b1, 16'h0022})
                        $display("FAIL after_skid_req: got req=%b addr=%h want req=1 addr=0022", imem.req, imem.addr);
                    else pass_cnt++;
                end
                last_del = i;
            end
        end
        stall = 1'b1;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL stall_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] e;
        bit          seen_req;
        sb.delete();
        ready_val = 1'b0;
        mem_lat   = 2;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0005;
        tick();
        redirect  = 1'b0;
        ready_val = 1'b1;
        tick();
        check_cnt++;
        if ({imem.req, imem.addr} !== {1'b0, 16'h0005})
            $display("FAIL wait_on_0005: got req=%b addr=%h want req=0 addr=0005", imem.req, imem.addr);
        else pass_cnt++;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL redirect_bubble: got %b want 0", out_valid);
        else pass_cnt++;
        sb.push_back(expv(16'h0100));
        sb.push_back(expv(16'h0101));
        seen_req = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
            if (!seen_req && imem.req) begin
                seen_req = 1'b1;
                check_cnt++;
                if (imem.addr !== 16'h0100) $display("FAIL redirect_target_req: got %h want 0100", imem.addr);
                else pass_cnt++;
            end
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL redirect_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
            end
        end
        stall   = 1'b1;
        mem_lat = 0;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL redirect_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_redirect_full();
        logic [31:0] e;
        sb.delete();
        ready_val = 1'b0;
        mem_lat   = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0030;
        tick();
        redirect  = 1'b0;
        ready_val = 1'b1;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check_cnt++;
        if (out_valid !== 1'b1) $display("FAIL reach_slot: got %b want 1", out_valid);
        else pass_cnt++;
        stall = 1'b1;
        tick();
        tick();
        check_cnt++;
        if ({imem.req, out_valid, out_PC} !== {1'b0, 1'b1, 16'h0030})
            $display("FAIL hold_full: got req=%b valid=%b pc=%h want req=0 valid=1 pc=0030", imem.req, out_valid, out_PC);
        else pass_cnt++;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check_cnt++;
        if (out_valid !== 1'b0) $display("FAIL flush_bubble: got %b want 0", out_valid);
        else pass_cnt++;
        check_cnt++;
        if ({imem.req, imem.addr} !== {1'b1, 16'h0200})
            $display("FAIL flush_restart_req: got req=%b addr=%h want req=1 addr=0200", imem.req, imem.addr);
        else pass_cnt++;
        sb.push_back(expv(16'h0200));
        sb.push_back(expv(16'h0201));
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL flush_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
            end
        end
        stall = 1'b1;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL flush_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        sb.delete();
        ready_val = 1'b0;
        mem_lat   = 0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect  = 1'b0;
        ready_val = 1'b1;
        sb.push_back(expv(16'hFFFF));
        sb.push_back(expv(16'h0000));
        sb.push_back(expv(16'h0001));
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            tick();
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL wrap_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
                if (e[15:0] == 16'hFFFF) begin
                    check_cnt++;
                    if ({imem.req, imem.addr} !== {1'b1, 16'h0000})
                        $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=0000", imem.req, imem.addr);
                    else pass_cnt++;
                end
            end
        end
        stall = 1'b1;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL wrap_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] e;
        bit          seen_valid;
        sb.delete();
        ready_val  = 1'b1;
        rand_ready = 1'b1;
        mem_lat    = 1;
        do_reset();
        seen_valid = 1'b0;
        for (int i = 0; i < 200 && !(seen_valid && !imem.req); i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check_cnt++;
        if ((seen_valid && !imem.req) !== 1'b1)
            $display("FAIL mid_wait_reached: got valid_seen=%b req=%b want 1 and 0", seen_valid, imem.req);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        check_cnt++;
        if ({out_valid, out_instruction, out_PC} !== 33'd0)
            $display("FAIL async_reset_out: got valid=%b instr=%h pc=%h want all 0", out_valid, out_instruction, out_PC);
        else pass_cnt++;
        check_cnt++;
        if (imem.req !== 1'b0) $display("FAIL async_reset_req: got %b want 0", imem.req);
        else pass_cnt++;
        tick();
        reset = 1'b1;
        #1;
        check_cnt++;
        if ({imem.req, imem.addr} !== {1'b1, 16'h0010})
            $display("FAIL resume_req: got req=%b addr=%h want req=1 addr=0010", imem.req, imem.addr);
        else pass_cnt++;
        sb.push_back(expv(16'h0010));
        sb.push_back(expv(16'h0011));
        sb.push_back(expv(16'h0012));
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            tick();
            if (out_valid && !stall) begin
                e = sb.pop_front();
                check_cnt++;
                if ({out_instruction, out_PC} !== e)
                    $display("FAIL resume_deliver: got {%h,%h} want {%h,%h}", out_instruction, out_PC, e[31:16], e[15:0]);
                else pass_cnt++;
            end
        end
        rand_ready = 1'b0;
        stall      = 1'b1;
        check_cnt++;
        if (sb.size() != 0) $display("FAIL resume_drained: got %0d left want 0", sb.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
